// File: rtl/prog_mem_loader.sv
// prog_mem_loader: serial bootloader that assembles UART bytes into 16-bit words and writes program memory.
// Latency: pm_we 1 clk after the high-byte strobe; load_done 1 clk after the last pm_we.
// Backpressure: none; a byte is accepted in any cycle rx_valid is high, including pm_we cycles.
// Ports: clk/rst_n (async active-low), rx_valid/rx_data byte stream in,
//   pm_we/pm_addr/pm_din memory write port, cpu_hold/busy session active,
//   load_done/load_err one-cycle session result pulses.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_mem_loader #(
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] START_BYTE  = 8'h55,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]       MAX_N    = 17'(2 ** ADDR_W);

  // S_FIN covers the cycle in which the last pm_we is high, so that
  // load_done lands one clock after it and cpu_hold drops with the pulse.
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_FIN, S_CHK
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_lo;
  logic [15:0]        r_rem;
  logic [ADDR_W-1:0]  r_waddr;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_hold;
  logic               r_pm_we, r_done, r_err;
  logic [ADDR_W-1:0]  r_pm_addr;
  logic [15:0]        r_pm_din;
  logic               w_we_nxt, w_done_nxt, w_err_nxt;

  wire [15:0] w_n       = {rx_data, r_lo};
  wire        w_start   = rx_valid && (rx_data == START_BYTE);
  wire        w_n_zero  = (w_n == 16'd0);
  wire        w_n_big   = ({1'b0, w_n} > MAX_N);
  wire        w_last    = (r_rem == 16'd1);
  // Timer expiry only matters while a byte is still owed; S_FIN never waits.
  wire        w_timeout = (r_state != S_IDLE) && (r_state != S_FIN) &&
                          !rx_valid && (r_tmr == TMR_LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  wire        w_sum_ok = (rx_data == r_sum);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start)  w_state_nxt = S_CNT_LO;
        S_CNT_LO: if (rx_valid) w_state_nxt = S_CNT_HI;
        S_CNT_HI: if (rx_valid) w_state_nxt = (w_n_zero || w_n_big) ? S_IDLE : S_DAT_LO;
        S_DAT_LO: if (rx_valid) w_state_nxt = S_DAT_HI;
        S_DAT_HI: if (rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_state_nxt = w_last ? S_CHK : S_DAT_LO;
`else
          w_state_nxt = w_last ? S_FIN : S_DAT_LO;
`endif
        end
        S_FIN:    w_state_nxt = S_IDLE;
        S_CHK:    if (rx_valid) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered strobes. Timeout needs
  // !rx_valid and excludes S_FIN, so done and err can never coincide.
  always_comb begin
    w_we_nxt   = (r_state == S_DAT_HI) && rx_valid;
    w_done_nxt = ((r_state == S_CNT_HI) && rx_valid && w_n_zero) || (r_state == S_FIN);
    w_err_nxt  = w_timeout || ((r_state == S_CNT_HI) && rx_valid && w_n_big);
`ifdef PROG_LOADER_CHECKSUM_EN
    if ((r_state == S_CHK) && rx_valid) begin
      w_done_nxt = w_sum_ok;
      w_err_nxt  = !w_sum_ok;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo      <= '0;
      r_rem     <= '0;
      r_waddr   <= '0;
      r_tmr     <= '0;
      r_hold    <= 1'b0;
      r_pm_we   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pm_addr <= '0;
      r_pm_din  <= '0;
    end else begin
      r_hold  <= (w_state_nxt != S_IDLE);
      r_pm_we <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;

      // Timer reloads on every byte and rests while idle
      if ((r_state == S_IDLE) || rx_valid) r_tmr <= '0;
      else                                 r_tmr <= r_tmr + TMR_W'(1);

      if (rx_valid && ((r_state == S_CNT_LO) || (r_state == S_DAT_LO)))
        r_lo <= rx_data;

      if ((r_state == S_IDLE) && w_start)
        r_waddr <= '0;

      if ((r_state == S_CNT_HI) && rx_valid)
        r_rem <= w_n;

      if (w_we_nxt) begin
        r_pm_addr <= r_waddr;
        r_pm_din  <= {rx_data, r_lo};
        r_waddr   <= r_waddr + ADDR_W'(1);
        r_rem     <= r_rem - 16'd1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sum <= '0;
    else if ((r_state == S_IDLE) && w_start)
      r_sum <= '0;
    else if (rx_valid && ((r_state == S_DAT_LO) || (r_state == S_DAT_HI)))
      r_sum <= r_sum + rx_data;
  end
`endif

  assign pm_we     = r_pm_we;
  assign pm_addr   = r_pm_addr;
  assign pm_din    = r_pm_din;
  assign cpu_hold  = r_hold;
  assign busy      = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed and randomized frames against a frame-level reference model.
// Latency: checks write timing relative to byte strobes and the idle timeout.
// Backpressure: none; bytes are driven as one-cycle strobes with random gaps.
module tb_prog_mem_loader;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        pm_we;
  logic [13:0] pm_addr;
  logic [15:0] pm_din;
  logic        cpu_hold, busy, load_done, load_err;

  prog_mem_loader #(.ADDR_W(14), .START_BYTE(8'h55), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_din(pm_din),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;

  logic [13:0] obs_addr[$];
  logic [15:0] obs_dat[$];
  int          obs_cyc[$];
  int done_cnt, err_cnt, done_cyc, err_cyc, hold_cnt, rule_mis;

  logic [7:0]  frame_q[$];
  logic [13:0] exp_addr[$];
  logic [15:0] exp_dat[$];
  int exp_done, exp_err;

  always @(posedge clk) cyc = cyc + 1;

  // Observation stamps use the number of the edge that produced the output
  always @(negedge clk) begin
    if (pm_we) begin
      obs_addr.push_back(pm_addr);
      obs_dat.push_back(pm_din);
      obs_cyc.push_back(cyc);
    end
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (load_err)  begin err_cnt++;  err_cyc  = cyc; end
    if (cpu_hold) hold_cnt++;
    if ((busy !== cpu_hold) || (load_done && load_err)) rule_mis++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_dat.delete(); obs_cyc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; hold_cnt = 0; rule_mis = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    last_edge = cyc + 1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (i != frame_q.size() - 1) idle($urandom_range(0, maxgap));
    end
  endtask

  // Reference: parse the byte list at frame level and list the words, result pulse
  task automatic model();
    int p;
    logic [15:0] n;
    logic [7:0] s;
    exp_addr.delete(); exp_dat.delete(); exp_done = 0; exp_err = 0;
    p = 0;
    while (p < frame_q.size() && frame_q[p] != 8'h55) p++;
    if (p + 2 >= frame_q.size()) begin exp_err = (p < frame_q.size()) ? 1 : 0; return; end
    n = {frame_q[p+2], frame_q[p+1]};
    p += 3;
    if (n == 16'd0)   begin exp_done = 1; return; end
    if (n > 16'd16384) begin exp_err = 1; return; end
    s = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      if (p + 1 >= frame_q.size()) begin exp_err = 1; return; end
      exp_addr.push_back(14'(i));
      exp_dat.push_back({frame_q[p+1], frame_q[p]});
      s = s + frame_q[p] + frame_q[p+1];
      p += 2;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (p >= frame_q.size()) exp_err = 1;
    else if (frame_q[p] == s) exp_done = 1;
    else exp_err = 1;
`else
    if (s == s) exp_done = 1;
`endif
  endtask

  task automatic add_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] s;
    int p;
    s = 8'h00;
    p = 0;
    while (p < frame_q.size() && frame_q[p] != 8'h55) p++;
    for (int i = p + 3; i < frame_q.size(); i++) s = s + frame_q[i];
    frame_q.push_back(s);
`endif
  endtask

  task automatic check_result(input string tag);
    int k;
    k = 0;
    while ((done_cnt + err_cnt) == 0 && k < TO + 20) begin idle(1); k++; end
    idle(3);
    model();
    chk({tag, ".nwr"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s.dat%0d", tag, i), obs_dat[i], exp_dat[i]);
    end
    chk({tag, ".done"}, done_cnt, exp_done);
    chk({tag, ".err"}, err_cnt, exp_err);
    chk({tag, ".hold_after"}, cpu_hold, 1'b0);
    chk({tag, ".rules"}, rule_mis, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"}, pm_we, 1'b0);
    chk({tag, ".hold"}, {cpu_hold, busy}, 2'b00);
    chk({tag, ".pulses"}, {load_done, load_err}, 2'b00);
    chk({tag, ".addr"}, pm_addr, 14'h0);
    chk({tag, ".din"}, pm_din, 16'h0);
  endtask

  initial begin
    int lw;
    logic [7:0] b;
    int nw;
    #1;
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 1: two-word load, back to back
    clear_obs();
    frame_q = '{8'h55, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    add_chk();
    send_frame(0);
    check_result("t1");
    lw = (obs_cyc.size() == 2) ? obs_cyc[1] : -100;
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("t1.we_lat", lw, last_edge);
    chk("t1.done_lat", done_cyc, lw + 1);
`endif

    // 2: idle junk ignored, then N=0
    clear_obs();
    frame_q = '{8'h00, 8'hAA, 8'hFF};
    send_frame(1);
    idle(2);
    chk("t2.idle_hold", hold_cnt, 0);
    clear_obs();
    frame_q = '{8'h55, 8'h00, 8'h00};
    send_frame(0);
    check_result("t2");
    chk("t2.hold_len", (hold_cnt >= 2 && hold_cnt <= 3), 1'b1);

    // 3: oversize N, then a good frame; also the 2**14 limit boundary above
    clear_obs();
    frame_q = '{8'h55, 8'h01, 8'h40};
    send_frame(2);
    check_result("t3a");
    clear_obs();
    frame_q = '{8'h55, 8'hFF, 8'hFF};
    send_frame(0);
    check_result("t3b");
    clear_obs();
    frame_q = '{8'h55, 8'h01, 8'h00, 8'h55, 8'h55};
    add_chk();
    send_frame(1);
    check_result("t3c");

    // 4: stall after one word and one low byte
    clear_obs();
    frame_q = '{8'h55, 8'h03, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    send_byte(8'h33);
    frame_q.push_back(8'h33);
    check_result("t4");
    chk("t4.to_cyc", err_cyc - last_edge, TO);

    // 5: reset mid-session, then restart at address 0
    clear_obs();
    frame_q = '{8'h55, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    send_frame(0);
    idle(1);
    chk("t5.addr_pre", pm_addr, 14'h1);
    chk("t5.hold_pre", cpu_hold, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("t5.rst");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_obs();
    frame_q = '{8'h55, 8'h01, 8'h00, 8'hEF, 8'hBE};
    add_chk();
    send_frame(2);
    check_result("t5");

    // Random frames with leading junk and random data bytes
    for (int f = 0; f < 8; f++) begin
      clear_obs();
      frame_q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h54;
        frame_q.push_back(b);
      end
      nw = $urandom_range(1, 6);
      frame_q.push_back(8'h55);
      frame_q.push_back(8'(nw));
      frame_q.push_back(8'h00);
      repeat (2 * nw) frame_q.push_back(8'($urandom_range(0, 255)));
      add_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] + 8'h01;
`endif
      send_frame(2);
      check_result($sformatf("rnd%0d", f));
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    clear_obs();
    frame_q = '{8'h55, 8'h01, 8'h00, 8'h10, 8'h20, 8'h30};
    send_frame(1);
    check_result("t6a");
    clear_obs();
    frame_q = '{8'h55, 8'h01, 8'h00, 8'h10, 8'h20, 8'h31};
    send_frame(1);
    check_result("t6b");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
